// File: rtl/motor_pkg.sv
// Shared motor-control types: FSM state codes, dead-time target, gate bundle.
// HBRIDGE_BRAKE_EN adds the S_BRAKE state (both low-side switches on).
package motor_pkg;

  localparam int unsigned DEAD_CYCLES_DEFAULT = 100;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_DEAD  = 3'd1,
    S_FWD   = 3'd2,
    S_REV   = 3'd3,
    S_FAULT = 3'd4
`ifdef HBRIDGE_BRAKE_EN
    , S_BRAKE = 3'd5
`endif
  } state_t;

  // Drive state to enter once the dead time has elapsed
  typedef enum logic [1:0] {
    T_REV   = 2'd0,
    T_FWD   = 2'd1,
    T_BRAKE = 2'd2
  } target_t;

  typedef struct packed {
    logic a_hi;
    logic a_lo;
    logic b_hi;
    logic b_lo;
  } gates_t;

  // Map a dead-time target onto the drive state it selects
  function automatic state_t target_state(input target_t t);
    state_t s;
    s = S_OFF;
    case (t)
      T_FWD:   s = S_FWD;
      T_REV:   s = S_REV;
`ifdef HBRIDGE_BRAKE_EN
      T_BRAKE: s = S_BRAKE;
`endif
      default: s = S_OFF;
    endcase
    return s;
  endfunction

  // Gate pattern for a state; only one switch per leg can ever be on
  function automatic gates_t gate_decode(input state_t s, input logic pwm);
    gates_t g;
    g = '0;
    case (s)
      S_FWD: begin
        g.a_hi = pwm;
        g.b_lo = 1'b1;
      end
      S_REV: begin
        g.b_hi = pwm;
        g.a_lo = 1'b1;
      end
`ifdef HBRIDGE_BRAKE_EN
      S_BRAKE: begin
        g.a_lo = 1'b1;
        g.b_lo = 1'b1;
      end
`endif
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic aclk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture into the aclk domain
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hbridge_driver.sv
// H-bridge gate driver: dead-time sequencing between drive directions,
// fault latch with explicit clear. HBRIDGE_BRAKE_EN adds the brake input
// and a low-side braking state.
module hbridge_driver
  import motor_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = DEAD_CYCLES_DEFAULT
) (
  input  logic       aclk,
  input  logic       rst_n,
  input  logic       pwm_in,
  input  logic       dir_in,
  input  logic       enable,
  input  logic       fault_n,
  input  logic       fault_clr,
`ifdef HBRIDGE_BRAKE_EN
  input  logic       brake,
`endif
  output logic       a_hi,
  output logic       a_lo,
  output logic       b_hi,
  output logic       b_lo,
  output logic       fault_latched,
  output logic [2:0] state_o
);

  localparam int unsigned CNT_W = $clog2(DEAD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYCLES - 1);

  logic             fault_s;
  state_t           state, state_d;
  target_t          target, target_d;
  target_t          want;
  logic [CNT_W-1:0] cnt, cnt_d;
  gates_t           gates, gates_d;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_fault_sync (
    .aclk (aclk),
    .rst_n(rst_n),
    .d    (fault_n),
    .q    (fault_s)
  );

  // Requested drive target; brake outranks direction
`ifdef HBRIDGE_BRAKE_EN
  assign want = brake ? T_BRAKE : (dir_in ? T_FWD : T_REV);
`else
  assign want = dir_in ? T_FWD : T_REV;
`endif

  // State, target and dead-time counter registers
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_OFF;
      target <= T_REV;
      cnt    <= '0;
    end else begin
      state  <= state_d;
      target <= target_d;
      cnt    <= cnt_d;
    end
  end

  // Next state: fault > enable low > brake/direction retarget > dead-time expiry
  always_comb begin
    state_d  = state;
    target_d = target;
    cnt_d    = cnt;
    if (!fault_s) begin
      state_d = S_FAULT;
    end else if (state == S_FAULT) begin
      if (fault_clr) state_d = S_OFF;
    end else if (!enable) begin
      state_d = S_OFF;
    end else begin
      case (state)
        S_OFF: begin
          state_d  = S_DEAD;
          target_d = want;
          cnt_d    = CNT_LOAD;
        end
        S_DEAD: begin
          if (want != target) begin
            target_d = want;
            cnt_d    = CNT_LOAD;
          end else if (cnt == '0) begin
            state_d = target_state(target);
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
`ifdef HBRIDGE_BRAKE_EN
        S_FWD, S_REV, S_BRAKE: begin
`else
        S_FWD, S_REV: begin
`endif
          if (want != target) begin
            state_d  = S_DEAD;
            target_d = want;
            cnt_d    = CNT_LOAD;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  // Gate decode; a synchronized fault drops the gates on the edge the FSM latches it
  always_comb begin
    gates_d = '0;
    if (fault_s) gates_d = gate_decode(state, pwm_in);
  end

  // Registered gate commands and fault indicator
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      gates         <= '0;
      fault_latched <= 1'b0;
    end else begin
      gates         <= gates_d;
      fault_latched <= (state_d == S_FAULT);
    end
  end

  assign a_hi    = gates.a_hi;
  assign a_lo    = gates.a_lo;
  assign b_hi    = gates.b_hi;
  assign b_lo    = gates.b_lo;
  assign state_o = 3'(state);

endmodule
